// File: rtl/bounce_generator.sv
// bounce_generator: turns a clean level into a switch-like bouncy signal.
// Each event emits 2N+1 transitions with per-level hold widths, then holds
// the final level stable for SETTLE_CYC clocks. Counts emitted transitions.
// Optional macro BOUNCE_GEN_LFSR_EN: pseudo-random hold widths from a 16-bit LFSR.
module bounce_generator #(
   parameter int unsigned MIN_W      = 4,
   parameter logic [15:0] W_MASK     = 16'h000F,
   parameter int unsigned SETTLE_CYC = 16,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clr,
   input  logic       i_lvl,
   input  logic [3:0] i_bounces,
   output logic       o_sw,
   output logic       o_busy,
   output logic [7:0] o_bounce_count,
   output logic [1:0] o_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, BOUNCE = 2'd1, SETTLE = 2'd2} state_e;

   localparam logic [15:0] MIN_W_M1  = 16'(MIN_W - 1);
   localparam logic [15:0] SETTLE_M1 = 16'(SETTLE_CYC - 1);

   state_e      state_q;
   logic        sw_q;
   logic        stable_q;
   logic        target_q;
   logic [4:0]  remain_q;
   logic [15:0] timer_q;
   logic [7:0]  count_q;
   logic [15:0] w_m1;     // hold width minus one for the level being loaded now
   logic        emit;     // o_sw changes on this edge

`ifdef BOUNCE_GEN_LFSR_EN
   logic [15:0] lfsr_q;

   // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right, free-running
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) lfsr_q <= SEED;
      else          lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
   end

   assign w_m1 = MIN_W_M1 + (lfsr_q & W_MASK);
`else
   // Fixed width: the random term folds to a constant zero
   assign w_m1 = MIN_W_M1 + (SEED & W_MASK & 16'h0000);
`endif

   // Flag the edges on which the FSM below changes o_sw
   always_comb begin
      emit = 1'b0;
      case (state_q)
         IDLE:    emit = (i_lvl != stable_q);
         BOUNCE:  emit = (timer_q == 16'd0);
         SETTLE:  emit = 1'b0;
         default: emit = (sw_q != stable_q);
      endcase
   end

   // Event FSM: first transition in IDLE, chatter in BOUNCE, quiet hold in SETTLE
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         sw_q     <= 1'b0;
         stable_q <= 1'b0;
         target_q <= 1'b0;
         remain_q <= 5'd0;
         timer_q  <= 16'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_lvl != stable_q) begin
                  target_q <= i_lvl;
                  sw_q     <= i_lvl;
                  if (i_bounces == 4'd0) begin
                     state_q <= SETTLE;
                     timer_q <= SETTLE_M1;
                  end else begin
                     state_q  <= BOUNCE;
                     remain_q <= {i_bounces, 1'b0};
                     timer_q  <= w_m1;
                  end
               end
            end
            BOUNCE: begin
               if (timer_q == 16'd0) begin
                  sw_q     <= ~sw_q;
                  remain_q <= remain_q - 5'd1;
                  if (remain_q == 5'd1) begin
                     state_q <= SETTLE;
                     timer_q <= SETTLE_M1;
                  end else begin
                     timer_q <= w_m1;
                  end
               end else begin
                  timer_q <= timer_q - 16'd1;
               end
            end
            SETTLE: begin
               if (timer_q == 16'd0) begin
                  stable_q <= target_q;
                  state_q  <= IDLE;
               end else begin
                  timer_q <= timer_q - 16'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               sw_q    <= stable_q;
            end
         endcase
      end
   end

   // Transition counter; clear takes priority over a same-cycle transition
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  count_q <= 8'd0;
      else if (i_clr) count_q <= 8'd0;
      else if (emit)  count_q <= count_q + 8'd1;
   end

   assign o_sw           = sw_q;
   assign o_busy         = (state_q != IDLE);
   assign o_state        = state_q;
   assign o_bounce_count = count_q;

endmodule
